// File: rtl/cn_ff_bank_arbiter.sv
// cn_ff_bank_arbiter: round-robin arbitration of two requesters onto a bank
// of CN flip-flop cells. A command is granted in IDLE, applied to one cell in
// APPLY and acknowledged in ACK, so at most one command lands per 3 cycles.
module cn_ff_bank_arbiter #(
  parameter int NUM_FF = 8,
  parameter int ADDR_W = 3,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_a,
  input  logic [ADDR_W-1:0] addr_a,
  input  logic              c_a,
  input  logic              n_a,
  output logic              ack_a,
  input  logic              req_b,
  input  logic [ADDR_W-1:0] addr_b,
  input  logic              c_b,
  input  logic              n_b,
  output logic              ack_b,
  output logic              err,
  output logic              busy,
  output logic [NUM_FF-1:0] q,
  output logic [NUM_FF-1:0] qbar,
  output logic [CNT_W-1:0]  op_count
);

  typedef enum logic [1:0] {IDLE, APPLY, ACK} state_t;

  state_t              state_reg, state_next;
  logic                grant;          // a request is accepted this cycle
  logic                grant_b;        // accepted request belongs to B
  logic                owner_reg;      // 0 = A, 1 = B
  logic                ptr_reg;        // priority side on contention, 0 = A
  logic [ADDR_W-1:0]   addr_reg;
  logic                c_reg, n_reg;
  logic                in_range;
  logic                apply;
  logic [NUM_FF-1:0]   bank_reg, bank_next;
  logic                ack_a_reg, ack_b_reg, err_reg, busy_reg;
  logic [CNT_W-1:0]    count_reg;

  // CN cell rule: 00 hold, 01 clear, 10 set, 11 toggle
  function automatic logic cn_next(input logic c, input logic n, input logic cur);
    case ({c, n})
      2'b01:   cn_next = 1'b0;
      2'b10:   cn_next = 1'b1;
      2'b11:   cn_next = ~cur;
      default: cn_next = cur;
    endcase
  endfunction

  assign apply    = (state_reg == APPLY);
  // Extra MSB keeps the compare meaningful when NUM_FF == 2**ADDR_W
  assign in_range = ({1'b0, addr_reg} < (ADDR_W+1)'(NUM_FF));

  // Per-cell next value: only the addressed cell changes, and only in APPLY
  generate
    for (genvar gi = 0; gi < NUM_FF; gi++) begin : g_cell
      assign bank_next[gi] = (apply && (addr_reg == ADDR_W'(gi)))
                             ? cn_next(c_reg, n_reg, bank_reg[gi])
                             : bank_reg[gi];
    end
  endgenerate

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  // Next-state and grant decision; contention resolved by the priority pointer
  always_comb begin
    state_next = state_reg;
    grant      = 1'b0;
    grant_b    = 1'b0;
    case (state_reg)
      IDLE: begin
        if (req_a || req_b) begin
          grant      = 1'b1;
          grant_b    = (req_a && req_b) ? ptr_reg : req_b;
          state_next = APPLY;
        end
      end
      APPLY:   state_next = ACK;
      ACK:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Command capture, bank update, registered status outputs and pointer rotation
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bank_reg  <= '0;
      ack_a_reg <= 1'b0;
      ack_b_reg <= 1'b0;
      err_reg   <= 1'b0;
      busy_reg  <= 1'b0;
      count_reg <= '0;
      ptr_reg   <= 1'b0;
      owner_reg <= 1'b0;
      addr_reg  <= '0;
      c_reg     <= 1'b0;
      n_reg     <= 1'b0;
    end else begin
      bank_reg  <= bank_next;
      ack_a_reg <= apply && !owner_reg;
      ack_b_reg <= apply && owner_reg;
      err_reg   <= apply && !in_range;
      busy_reg  <= (state_next != IDLE);
      if (apply && in_range) count_reg <= count_reg + CNT_W'(1);
      if (grant) begin
        owner_reg <= grant_b;
        addr_reg  <= grant_b ? addr_b : addr_a;
        c_reg     <= grant_b ? c_b : c_a;
        n_reg     <= grant_b ? n_b : n_a;
      end
      if (state_reg == ACK) ptr_reg <= !owner_reg;
    end
  end

  assign ack_a    = ack_a_reg;
  assign ack_b    = ack_b_reg;
  assign err      = err_reg;
  assign busy     = busy_reg;
  assign op_count = count_reg;
  assign q        = bank_reg;
  assign qbar     = ~bank_reg;

endmodule

// File: tb/tb_cn_ff_bank_arbiter.sv
// Bench for cn_ff_bank_arbiter: two instances (8 cells / 8-bit counter and
// 6 cells / 2-bit counter) share one stimulus stream. A transaction-level
// model predicts every output each cycle; directed literals pin the model.
module tb_cn_ff_bank_arbiter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req_a = 1'b0, c_a = 1'b0, n_a = 1'b0;
  logic       req_b = 1'b0, c_b = 1'b0, n_b = 1'b0;
  logic [2:0] addr_a = '0, addr_b = '0;

  logic       ack_a8, ack_b8, err8, busy8;
  logic [7:0] q8, qbar8, cnt8;
  logic       ack_a6, ack_b6, err6, busy6;
  logic [5:0] q6, qbar6;
  logic [1:0] cnt6;

  int compared = 0;
  int mismatched = 0;

  // Model state, index 0 = 8-cell instance, index 1 = 6-cell instance
  logic [7:0] m_q    [2];
  int         m_cnt  [2];
  bit         m_ptr  [2];   // side favoured on contention, 1 = B
  int         m_left [2];   // edges remaining until the command completes
  bit         m_own  [2];
  logic [2:0] m_addr [2];
  bit         m_c [2], m_n [2];
  bit         m_acka [2], m_ackb [2], m_err [2], m_busy [2];

  logic [7:0] order;
  int         last_t;

  always #5 clk = ~clk;

  cn_ff_bank_arbiter #(.NUM_FF(8), .ADDR_W(3), .CNT_W(8)) dut8 (
    .clk(clk), .rst_n(rst_n),
    .req_a(req_a), .addr_a(addr_a), .c_a(c_a), .n_a(n_a), .ack_a(ack_a8),
    .req_b(req_b), .addr_b(addr_b), .c_b(c_b), .n_b(n_b), .ack_b(ack_b8),
    .err(err8), .busy(busy8), .q(q8), .qbar(qbar8), .op_count(cnt8)
  );

  cn_ff_bank_arbiter #(.NUM_FF(6), .ADDR_W(3), .CNT_W(2)) dut6 (
    .clk(clk), .rst_n(rst_n),
    .req_a(req_a), .addr_a(addr_a), .c_a(c_a), .n_a(n_a), .ack_a(ack_a6),
    .req_b(req_b), .addr_b(addr_b), .c_b(c_b), .n_b(n_b), .ack_b(ack_b6),
    .err(err6), .busy(busy6), .q(q6), .qbar(qbar6), .op_count(cnt6)
  );

  function automatic int nff(input int i);
    return (i == 0) ? 8 : 6;
  endfunction

  function automatic int cw(input int i);
    return (i == 0) ? 8 : 2;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance the model across one rising edge using the inputs present there
  task automatic model_step();
    for (int i = 0; i < 2; i++) begin
      m_acka[i] = 0; m_ackb[i] = 0; m_err[i] = 0;
      if (!rst_n) begin
        m_q[i] = '0; m_cnt[i] = 0; m_ptr[i] = 0; m_left[i] = 0; m_busy[i] = 0;
      end else if (m_left[i] == 0) begin
        if (req_a || req_b) begin
          m_own[i]  = (req_a && req_b) ? m_ptr[i] : req_b;
          m_addr[i] = m_own[i] ? addr_b : addr_a;
          m_c[i]    = m_own[i] ? c_b : c_a;
          m_n[i]    = m_own[i] ? n_b : n_a;
          m_left[i] = 2; m_busy[i] = 1;
        end
      end else if (m_left[i] == 2) begin
        if (int'(m_addr[i]) < nff(i)) begin
          if (m_c[i] && m_n[i])  m_q[i][m_addr[i]] = ~m_q[i][m_addr[i]];
          else if (m_c[i])       m_q[i][m_addr[i]] = 1'b1;
          else if (m_n[i])       m_q[i][m_addr[i]] = 1'b0;
          m_cnt[i] = (m_cnt[i] + 1) % (1 << cw(i));
        end else begin
          m_err[i] = 1;
        end
        if (m_own[i]) m_ackb[i] = 1; else m_acka[i] = 1;
        m_left[i] = 1;
      end else begin
        m_ptr[i] = !m_own[i]; m_busy[i] = 0; m_left[i] = 0;
      end
    end
  endtask

  // One clock: model update on the edge, then full output comparison
  task automatic cycle();
    logic [7:0] e8;
    logic [5:0] e6;
    @(posedge clk);
    model_step();
    #1;
    e8 = ~m_q[0];
    e6 = ~m_q[1][5:0];
    chk("q8", q8, m_q[0]);
    chk("qbar8", qbar8, e8);
    chk("ack_a8", ack_a8, m_acka[0]);
    chk("ack_b8", ack_b8, m_ackb[0]);
    chk("err8", err8, m_err[0]);
    chk("busy8", busy8, m_busy[0]);
    chk("cnt8", cnt8, m_cnt[0]);
    chk("q6", q6, m_q[1][5:0]);
    chk("qbar6", qbar6, e6);
    chk("ack_a6", ack_a6, m_acka[1]);
    chk("ack_b6", ack_b6, m_ackb[1]);
    chk("err6", err6, m_err[1]);
    chk("busy6", busy6, m_busy[1]);
    chk("cnt6", cnt6, m_cnt[1]);
  endtask

  // Hold requests until nacks acknowledges arrive; returns in the ack cycle
  task automatic issue(input bit ra, input bit rb,
                       input logic [2:0] aa, input bit ca, input bit na,
                       input logic [2:0] ab, input bit cb, input bit nb,
                       input int nacks);
    int got;
    int t;
    got = 0; t = 0; order = '0;
    req_a = ra; addr_a = aa; c_a = ca; n_a = na;
    req_b = rb; addr_b = ab; c_b = cb; n_b = nb;
    while (got < nacks && t < 6 * nacks + 10) begin
      cycle();
      t++;
      if (m_acka[0]) begin order = {order[6:0], 1'b0}; got++; end
      if (m_ackb[0]) begin order = {order[6:0], 1'b1}; got++; end
    end
    last_t = t;
    chk("issue_acks", got, nacks);
    req_a = 1'b0; req_b = 1'b0;
  endtask

  initial begin
    logic [7:0] exp4 [4];
    logic [1:0] code [4];
    exp4 = '{8'hA1, 8'hA1, 8'h81, 8'h81};
    code = '{2'b10, 2'b00, 2'b11, 2'b01};

    // Reset, then idle
    rst_n = 1'b0;
    cycle(); cycle();
    rst_n = 1'b1;
    repeat (5) cycle();
    chk("t1_q", q8, 8'h00);
    chk("t1_qbar", qbar8, 8'hFF);
    chk("t1_qbar6", qbar6, 6'h3F);
    chk("t1_busy", busy8, 1'b0);
    chk("t1_cnt", cnt8, 8'd0);

    // Single A command: set cell 3, then toggle it back
    issue(1, 0, 3'd3, 1, 0, 3'd0, 0, 0, 1);
    chk("t2_latency", last_t, 2);
    chk("t2_ack", ack_a8, 1'b1);
    chk("t2_busy_ack", busy8, 1'b1);
    chk("t2_q", q8, 8'h08);
    chk("t2_cnt", cnt8, 8'd1);
    cycle();
    chk("t2_ack_one_cycle", ack_a8, 1'b0);
    chk("t2_busy_done", busy8, 1'b0);
    issue(1, 0, 3'd3, 1, 1, 3'd0, 0, 0, 1);
    chk("t2_q_toggle", q8, 8'h00);
    chk("t2_cnt2", cnt8, 8'd2);

    // Contention after reset: strict alternation starting at A
    rst_n = 1'b0;
    cycle();
    rst_n = 1'b1;
    issue(1, 1, 3'd0, 1, 0, 3'd7, 1, 0, 4);
    chk("t3_order", order[3:0], 4'b0101);
    chk("t3_q", q8, 8'h81);
    chk("t3_cnt", cnt8, 8'd4);
    chk("t3_q6", q6, 6'h01);
    chk("t3_cnt6", cnt6, 2'd2);

    // B walks all four encodings on cell 5
    for (int k = 0; k < 4; k++) begin
      issue(0, 1, 3'd0, 0, 0, 3'd5, code[k][1], code[k][0], 1);
      chk("t4_q", q8, exp4[k]);
    end

    // Out-of-range address on the 6-cell instance
    issue(1, 0, 3'd7, 1, 0, 3'd0, 0, 0, 1);
    chk("t5_ack6", ack_a6, 1'b1);
    chk("t5_err6", err6, 1'b1);
    chk("t5_err8", err8, 1'b0);
    chk("t5_q6", q6, 6'h01);
    chk("t5_cnt6", cnt6, 2'd2);
    chk("t5_cnt8", cnt8, 8'd9);
    cycle();

    // Reset during APPLY drops the command
    req_a = 1'b1; addr_a = 3'd1; c_a = 1'b1; n_a = 1'b0;
    cycle();
    rst_n = 1'b0; req_a = 1'b0;
    cycle();
    chk("t6_ack", ack_a8, 1'b0);
    chk("t6_q", q8, 8'h00);
    chk("t6_busy", busy8, 1'b0);
    rst_n = 1'b1;
    cycle();
    chk("t6_ack_after", ack_a8, 1'b0);
    chk("t6_q_after", q8, 8'h00);

    // Counter wrap on the 2-bit instance
    issue(1, 0, 3'd2, 1, 1, 3'd0, 0, 0, 5);
    chk("t6_cnt6_wrap", cnt6, 2'd1);
    chk("t6_cnt8", cnt8, 8'd5);
    chk("t6_q_wrap", q8, 8'h04);

    // Randomized traffic with occasional resets
    for (int cyc = 0; cyc < 3000; cyc++) begin
      rst_n = ($urandom_range(0, 99) != 0);
      if (!req_a && $urandom_range(0, 2) == 0) begin
        req_a = 1'b1; addr_a = 3'($urandom_range(0, 7));
        c_a = 1'($urandom); n_a = 1'($urandom);
      end
      if (!req_b && $urandom_range(0, 2) == 0) begin
        req_b = 1'b1; addr_b = 3'($urandom_range(0, 7));
        c_b = 1'($urandom); n_b = 1'($urandom);
      end
      cycle();
      if (m_acka[0]) begin
        if ($urandom_range(0, 1) == 0) req_a = 1'b0;
        else begin
          addr_a = 3'($urandom_range(0, 7)); c_a = 1'($urandom); n_a = 1'($urandom);
        end
      end
      if (m_ackb[0]) begin
        if ($urandom_range(0, 1) == 0) req_b = 1'b0;
        else begin
          addr_b = 3'($urandom_range(0, 7)); c_b = 1'($urandom); n_b = 1'($urandom);
        end
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/cn_ff_bank_arbiter.md
Name: cn_ff_bank_arbiter

Overview:
Owns a bank of NUM_FF CN-type flip-flop cells and shares write access to them between two requesters, A and B.
Each requester issues a (c, n) command addressed to one cell. A round-robin arbiter picks one request at a time, and a three-state sequencer applies the command and returns a one-cycle acknowledge.
The block sits between the control logic and the CN storage bank, so the bank is never written by two masters in the same cycle.

Parameters:
NUM_FF, 8, number of CN cells in the bank (2..256)
ADDR_W, 3, cell address width; must satisfy 2**ADDR_W >= NUM_FF
CNT_W, 8, width of the completed-operation counter

Ports:
clk  input  1  single system clock, all state updates on its rising edge
rst_n  input  1  synchronous reset, active-low; sampled on rising clk edge
req_a  input  1  requester A command request; held high until ack_a
addr_a  input  ADDR_W  requester A target cell index
c_a  input  1  requester A C command bit
n_a  input  1  requester A N command bit
ack_a  output  1  one-cycle pulse: A's command has been applied
req_b  input  1  requester B command request; held high until ack_b
addr_b  input  ADDR_W  requester B target cell index
c_b  input  1  requester B C command bit
n_b  input  1  requester B N command bit
ack_b  output  1  one-cycle pulse: B's command has been applied
err  output  1  pulses together with ack_x when the captured address is >= NUM_FF
busy  output  1  high while a command is in flight (states APPLY and ACK)
q  output  NUM_FF  bank contents, one bit per cell
qbar  output  NUM_FF  always the bitwise inverse of q
op_count  output  CNT_W  number of successfully applied commands; wraps modulo 2**CNT_W

Behaviour:
- Reset (rst_n=0 at a rising edge):
  - q=0, qbar=all ones;
  - ack_a=0, ack_b=0, err=0, busy=0, op_count=0;
  - priority pointer = A; state = IDLE.
- CN cell encoding, applied to q[addr]:
  - c=0,n=0: hold
  - c=0,n=1: clear to 0
  - c=1,n=0: set to 1
  - c=1,n=1: toggle
- States: IDLE, APPLY, ACK.
- IDLE:
  - If no request is pending, stay in IDLE.
  - If exactly one of req_a/req_b is high, grant that requester.
  - If both are high, grant the side named by the priority pointer.
  - On grant: capture the granted addr, c and n into command registers, record the owner, go to APPLY.
- APPLY (one cycle):
  - If the captured addr < NUM_FF, update q[addr] per the encoding; no other cell changes.
  - Go to ACK.
- ACK (one cycle):
  - ack_owner=1; err=1 if the addr was out of range.
  - op_count increments only if the addr was in range.
  - The priority pointer moves to the non-owner side.
  - Go to IDLE.
- Outputs: ack_x, err, busy and op_count are all registered.
- Latency and throughput:
  - A request first seen at edge k is applied to q at edge k+1.
  - ack is high for the cycle between edges k+1 and k+2.
  - The next grant can occur at edge k+3, giving at most one command per 3 cycles.
- Request inputs:
  - Sampled only in IDLE; they are don't-care during APPLY and ACK.
  - A requester that keeps req high after its ack is re-arbitrated as a fresh request in the following IDLE cycle.
- Fairness:
  - With both requests continuously asserted, grants strictly alternate A, B, A, B starting from the pointer.
  - A lone requester is served back-to-back regardless of the pointer.
- Commands to the same cell from both requesters are applied in grant order, never merged.
- op_count wraps from 2**CNT_W-1 to 0 with no flag.
- Reset mid-operation: a reset at any state returns to IDLE with reset values on that edge. An in-flight command that has not yet reached its APPLY edge is dropped and produces no ack.
- qbar is driven combinationally as ~q and is valid in every cycle, including reset.

Test Plan:
1. Reset then idle for 5 cycles -> q=8'h00, qbar=8'hFF, busy=0, ack_a=ack_b=0, op_count=0.
2. A requests addr=3, c=1,n=0 -> q=8'h08 one edge after grant; ack_a high exactly one cycle, 2 edges after grant; op_count=1; a second A command addr=3, c=1,n=1 -> q=8'h00, op_count=2.
3. req_a and req_b asserted together for 4 grants after reset, A set addr 0, B set addr 7 -> grant order A,B,A,B; ack_a/ack_b alternate; q=8'h81; op_count=4.
4. B issues the four encodings in sequence to addr 5 (set, hold, toggle, clear) -> q[5] = 1,1,0,0; other bits unchanged.
5. NUM_FF=6 with ADDR_W=3, A addr=7, c=1,n=0 -> ack_a=1 and err=1 in the same cycle; q unchanged; op_count unchanged.
6. rst_n driven low in the APPLY cycle -> no ack and q=0 on the next edge, and state is IDLE. Separately, with CNT_W=2, run 5 commands -> op_count ends at 1 (wraps).
